// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared widths, types and FSM encoding for the frame-buffer rectangle writer
package fb_pkg;

  localparam int FB_ADDR_W  = 19;
  localparam int FB_PIX_W   = 24;
  localparam int FB_COORD_W = 10;

  typedef logic [FB_COORD_W-1:0] coord_t;
  typedef logic [FB_ADDR_W-1:0]  fb_addr_t;
  typedef logic [FB_PIX_W-1:0]   pixel_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t w;
    coord_t h;
    pixel_t color;
  } fb_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fb_wr_state_e;

endpackage

// File: rtl/fb_rect_addr_gen.sv
// rtl/fb_rect_addr_gen.sv - column/row counters and row-stride address generator
// addr_next_o is the address the write port will present after this edge.
module fb_rect_addr_gen
  import fb_pkg::*;
#(
  parameter int SCREEN_WIDTH = 640
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     load_i,
  input  logic     advance_i,
  input  fb_addr_t base_i,
  input  coord_t   w_i,
  input  coord_t   h_i,
  output fb_addr_t addr_o,
  output fb_addr_t addr_next_o,
  output logic     last_pixel_o
);

  localparam fb_addr_t STRIDE = fb_addr_t'(SCREEN_WIDTH);

  coord_t   col_q, col_d;
  coord_t   row_q, row_d;
  fb_addr_t addr_q, addr_d;
  fb_addr_t row_start_q, row_start_d;
  logic     end_of_row;

  assign end_of_row   = (col_q == w_i - coord_t'(1));
  assign last_pixel_o = end_of_row && (row_q == h_i - coord_t'(1));
  assign addr_o       = addr_q;
  assign addr_next_o  = addr_d;

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    addr_d      = addr_q;
    row_start_d = row_start_q;
    if (load_i) begin
      col_d       = '0;
      row_d       = '0;
      addr_d      = base_i;
      row_start_d = base_i;
    end else if (advance_i) begin
      if (end_of_row) begin
        // Jump by the stride from the row start, not from the current address.
        col_d       = '0;
        row_d       = row_q + coord_t'(1);
        addr_d      = row_start_q + STRIDE;
        row_start_d = row_start_q + STRIDE;
      end else begin
        col_d  = col_q + coord_t'(1);
        addr_d = addr_q + fb_addr_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      row_start_q <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      row_start_q <= row_start_d;
    end
  end

endmodule

// File: rtl/fb_rect_writer.sv
// rtl/fb_rect_writer.sv - rectangle-fill engine driving the frame-buffer RAM write port
// Optional FB_RECT_CLIP_EN clamps rectangles to the screen at accept time.
module fb_rect_writer
  import fb_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int COLOR_DEPTH   = 8
) (
  input  logic                     vga_clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [FB_COORD_W-1:0]    cmd_x,
  input  logic [FB_COORD_W-1:0]    cmd_y,
  input  logic [FB_COORD_W-1:0]    cmd_w,
  input  logic [FB_COORD_W-1:0]    cmd_h,
  input  logic [3*COLOR_DEPTH-1:0] cmd_color,
  output logic [FB_ADDR_W-1:0]     wr_addr,
  output logic [3*COLOR_DEPTH-1:0] wr_data,
  output logic                     wr_en,
  output logic                     busy,
  output logic                     done
);

  localparam int       PIX_W  = 3 * COLOR_DEPTH;
  localparam fb_addr_t STRIDE = fb_addr_t'(SCREEN_WIDTH);
  localparam fb_addr_t FB_MAX = fb_addr_t'(SCREEN_WIDTH * SCREEN_HEIGHT);
`ifdef FB_RECT_CLIP_EN
  localparam coord_t SCR_W = coord_t'(SCREEN_WIDTH);
  localparam coord_t SCR_H = coord_t'(SCREEN_HEIGHT);
`endif

  fb_wr_state_e      state_q, state_d;
  coord_t            w_q, w_d;
  coord_t            h_q, h_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              load;
  fb_cmd_t           cmd_in;
  fb_addr_t          base;
  fb_addr_t          addr_next;
  logic              last_pixel;

  always_comb begin
    cmd_in = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: pixel_t'(cmd_color)};
`ifdef FB_RECT_CLIP_EN
    if (cmd_x >= SCR_W || cmd_y >= SCR_H) begin
      cmd_in.w = '0;
      cmd_in.h = '0;
    end else begin
      if (cmd_w > SCR_W - cmd_x) cmd_in.w = SCR_W - cmd_x;
      if (cmd_h > SCR_H - cmd_y) cmd_in.h = SCR_H - cmd_y;
    end
`endif
  end

  assign base = fb_addr_t'(cmd_in.y) * STRIDE + fb_addr_t'(cmd_in.x);

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    wr_data_d = wr_data_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          load      = 1'b1;
          w_d       = cmd_in.w;
          h_d       = cmd_in.h;
          wr_data_d = PIX_W'(cmd_in.color);
          state_d   = (cmd_in.w == '0 || cmd_in.h == '0) ? DONE : FILL;
        end
      end
      FILL:    if (last_pixel) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Off-frame addresses still take their cycle; only the strobe is dropped.
    wr_en_d = (state_d == FILL) && (addr_next < FB_MAX);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
    end
  end

  fb_rect_addr_gen #(
    .SCREEN_WIDTH(SCREEN_WIDTH)
  ) u_addr_gen (
    .clk_i       (vga_clk),
    .rst_ni      (reset_n),
    .load_i      (load),
    .advance_i   (state_q == FILL),
    .base_i      (base),
    .w_i         (w_q),
    .h_i         (h_q),
    .addr_o      (wr_addr),
    .addr_next_o (addr_next),
    .last_pixel_o(last_pixel)
  );

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == FILL);
  assign done      = (state_q == DONE);
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// tb/tb_fb_rect_writer.sv - self-checking bench for fb_rect_writer
module tb_fb_rect_writer;

  logic        vga_clk   = 1'b0;
  logic        reset_n   = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [23:0] cmd_color = '0;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_en, busy, done;

  fb_rect_writer dut (
    .vga_clk  (vga_clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x    (cmd_x),
    .cmd_y    (cmd_y),
    .cmd_w    (cmd_w),
    .cmd_h    (cmd_h),
    .cmd_color(cmd_color),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc++;

  typedef struct {int cyc; int addr; int data;} wr_t;
  typedef struct {int idx; int addr;} ex_t;
  wr_t wq[$];
  int  dq[$];
  bit  ready_at[int];
  bit  busy_at[int];

  always @(negedge vga_clk) begin
    wr_t t;
    if (wr_en) begin
      t.cyc = cyc; t.addr = int'(wr_addr); t.data = int'(wr_data);
      wq.push_back(t);
    end
    if (done) dq.push_back(cyc);
    ready_at[cyc] = cmd_ready;
    busy_at[cyc]  = busy;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input int x, input int y, input int w, input int h, input int color,
                       output int a);
    bit r;
    cmd_x = 10'(x); cmd_y = 10'(y); cmd_w = 10'(w); cmd_h = 10'(h);
    cmd_color = 24'(color);
    cmd_valid = 1'b1;
    a = -1;
    for (int n = 0; n < 2000; n++) begin
      r = cmd_ready;
      @(posedge vga_clk);
      #1;
      if (r) begin a = cyc; break; end
    end
    cmd_valid = 1'b0;
    if (a < 0) chk("accept_timeout", 0, 1);
  endtask

  // Reference: list of (pixel index, address) that must be written, from the fill rules.
  task automatic check_cmd(input string nm, input int x, input int y, input int w, input int h,
                           input int color, input int a);
    int ew, eh, n, k, addr;
    ex_t e;
    ex_t ex[$];
    wr_t g;
    ew = w; eh = h;
`ifdef FB_RECT_CLIP_EN
    if (x >= 640 || y >= 480) begin ew = 0; eh = 0; end
    else begin
      if (w > 640 - x) ew = 640 - x;
      if (h > 480 - y) eh = 480 - y;
    end
`endif
    n = ew * eh;
    for (int r = 0; r < eh; r++)
      for (int c = 0; c < ew; c++) begin
        addr = ((y + r) * 640 + x + c) & 32'h7FFFF;
        if (addr < 307200) begin e.idx = r * ew + c; e.addr = addr; ex.push_back(e); end
      end
    k = 0;
    while (dq.size() == 0 && k < 20000) begin @(negedge vga_clk); k++; end
    if (dq.size() == 0) chk({nm, " done_timeout"}, 0, 1);
    else chk({nm, " done_cycle"}, dq.pop_front(), a + n);
    repeat (2) @(negedge vga_clk);
    foreach (ex[i]) begin
      if (wq.size() == 0) chk({nm, " missing_write"}, i, -1);
      else begin
        g = wq.pop_front();
        chk({nm, " wr_addr"}, g.addr, ex[i].addr);
        chk({nm, " wr_data"}, g.data, color & 24'hFFFFFF);
        chk({nm, " wr_cycle"}, g.cyc, a + ex[i].idx);
      end
    end
    chk({nm, " busy_first"}, busy_at.exists(a) && busy_at[a], n > 0);
    chk({nm, " ready_low_in_done"}, ready_at.exists(a + n) && ready_at[a + n], 0);
    chk({nm, " ready_after_done"}, ready_at.exists(a + n + 1) && ready_at[a + n + 1], 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, a2, rx, ry, rw, rh, rc;
    wr_t g;

    repeat (3) @(negedge vga_clk);
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset wr_en", wr_en, 0);
    chk("reset wr_addr", wr_addr, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    #1 reset_n = 1'b1;
    @(negedge vga_clk);
    chk("post_reset cmd_ready", cmd_ready, 1);
    chk("post_reset wr_en", wr_en, 0);

    issue(0, 0, 4, 2, 24'hFF0000, a);
    check_cmd("rect4x2", 0, 0, 4, 2, 24'hFF0000, a);

    issue(639, 479, 1, 1, 24'h00FF00, a);
    check_cmd("corner", 639, 479, 1, 1, 24'h00FF00, a);

    issue(5, 7, 0, 5, 24'h123456, a);
    check_cmd("zero_w", 5, 7, 0, 5, 24'h123456, a);

    issue(20, 30, 3, 3, 24'hAAAAAA, a);
    issue(100, 40, 2, 2, 24'h555555, a2);
    chk("b2b accept_cycle", a2, a + 9 + 2);
    check_cmd("b2b_first", 20, 30, 3, 3, 24'hAAAAAA, a);
    check_cmd("b2b_second", 100, 40, 2, 2, 24'h555555, a2);

    issue(636, 0, 8, 2, 24'h0000FF, a);
    check_cmd("overhang", 636, 0, 8, 2, 24'h0000FF, a);

    issue(600, 479, 50, 2, 24'h0F0F0F, a);
    check_cmd("bottom_edge", 600, 479, 50, 2, 24'h0F0F0F, a);

    issue(700, 10, 3, 2, 24'h777777, a);
    check_cmd("offscreen_x", 700, 10, 3, 2, 24'h777777, a);

    for (int i = 0; i < 12; i++) begin
      rx = $urandom_range(0, 700);
      ry = $urandom_range(0, 500);
      rw = $urandom_range(0, 10);
      rh = $urandom_range(0, 5);
      rc = $urandom & 24'hFFFFFF;
      issue(rx, ry, rw, rh, rc, a);
      check_cmd("random", rx, ry, rw, rh, rc, a);
    end

    issue(10, 10, 8, 8, 24'hC0FFEE, a);
    @(posedge vga_clk);
    @(posedge vga_clk);
    @(negedge vga_clk);
    #1 reset_n = 1'b0;
    #1 chk("abort wr_en_async", wr_en, 0);
    for (int i = 0; i < 3; i++) begin
      if (wq.size() == 0) chk("abort missing_write", i, -1);
      else begin
        g = wq.pop_front();
        chk("abort wr_addr", g.addr, 10 * 640 + 10 + i);
        chk("abort wr_cycle", g.cyc, a + i);
      end
    end
    repeat (3) begin
      @(negedge vga_clk);
      chk("in_reset wr_en", wr_en, 0);
      chk("in_reset busy", busy, 0);
    end
    #1 reset_n = 1'b1;
    repeat (4) begin
      @(negedge vga_clk);
      chk("after_abort wr_en", wr_en, 0);
      chk("after_abort cmd_ready", cmd_ready, 1);
    end
    chk("abort no_done", dq.size(), 0);
    chk("abort no_stray_write", wq.size(), 0);

    issue(3, 4, 5, 2, 24'h00ABCD, a);
    check_cmd("post_abort", 3, 4, 5, 2, 24'h00ABCD, a);

    repeat (3) @(negedge vga_clk);
    chk("final no_stray_write", wq.size(), 0);
    chk("final no_stray_done", dq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
